// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI controller: FSM state encoding and frame edge count.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int DEF_LENGTH_TX = 8;
  localparam int DEF_LENGTH_RX = 8;

  // Rising SCK edges per frame: tx bits, one turnaround edge, rx bits.
  function automatic int frame_edges(int length_tx, int length_rx);
    return length_tx + 1 + length_rx;
  endfunction

  localparam int FRAME_EDGES = frame_edges(DEF_LENGTH_TX, DEF_LENGTH_RX);

endpackage

// File: rtl/spi_controller_sck_gen.sv
// SCK generator: half-period divider, SCK toggle, and one-cycle strobes on the clk edge
// where SCK will be driven high (rise) or low (fall).
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == LAST);
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  // Disabling parks SCK low and restarts the divider so each frame begins aligned.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI controller: sends LENGTH_TX bits LSB-first, one turnaround SCK cycle, then receives LENGTH_RX bits.
// state | meaning: IDLE wait start | SHIFT clocking SCK | HOLD CS low after last edge | GAP CS high spacing
module spi_controller
  import spi_pkg::*;
#(
  parameter int LENGTH_TX    = 8,
  parameter int LENGTH_RX    = 8,
  parameter int CLK_DIV      = 4,
  parameter int CS_GAP       = 4,
  parameter int LENGTH_COUNT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LENGTH_TX-1:0] tx_data,
  output logic                 busy,
  output logic                 done,
  output logic [LENGTH_RX-1:0] rx_data,
  output logic                 SCK,
  output logic                 COPI,
  input  logic                 CIPO,
  output logic                 CS
);

  localparam int FRAME = frame_edges(LENGTH_TX, LENGTH_RX);
  localparam int WW    = $clog2(CLK_DIV + CS_GAP + 1);

  localparam logic [LENGTH_COUNT-1:0] K_TX   = LENGTH_COUNT'(LENGTH_TX);
  localparam logic [LENGTH_COUNT-1:0] K_RX0  = LENGTH_COUNT'(LENGTH_TX + 1);
  localparam logic [LENGTH_COUNT-1:0] K_LAST = LENGTH_COUNT'(FRAME);
  localparam logic [WW-1:0]           HOLD_LAST = WW'(CLK_DIV - 1);
  localparam logic [WW-1:0]           GAP_LAST  = WW'(CS_GAP - 1);

  state_t                  state;
  logic [LENGTH_TX-1:0]    tx_sh;
  logic [LENGTH_RX-1:0]    rx_sh;
  logic [LENGTH_COUNT-1:0] edge_cnt;
  logic [WW-1:0]           wait_cnt;
  logic                    sck_en;
  logic                    rise;
  logic                    fall;

  assign sck_en = (state == SHIFT);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk (clk),
    .rst (rst),
    .en  (sck_en),
    .sck (SCK),
    .rise(rise),
    .fall(fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      CS       <= 1'b1;
      COPI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh    <= tx_data;
            COPI     <= tx_data[0];
            CS       <= 1'b0;
            busy     <= 1'b1;
            edge_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // edge_cnt still holds the previous k here, so k > LENGTH_TX+1 means edge_cnt >= LENGTH_TX+1.
          if (rise) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt >= K_RX0) rx_sh <= {CIPO, rx_sh[LENGTH_RX-1:1]};
          end
          if (fall) begin
            if (edge_cnt < K_TX) begin
              COPI  <= tx_sh[1];
              tx_sh <= tx_sh >> 1;
            end else begin
              COPI <= 1'b0;
            end
            if (edge_cnt == K_LAST) begin
              wait_cnt <= '0;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (wait_cnt == HOLD_LAST) begin
            CS       <= 1'b1;
            done     <= 1'b1;
            rx_data  <= rx_sh;
            wait_cnt <= '0;
            state    <= GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          if (wait_cnt == GAP_LAST) begin
            busy     <= 1'b0;
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Randomized scoreboard bench: three controller lanes (8/8 div2, 8/8 div1, 4/12 div7) checked
// against a behavioural SPI peripheral and frame-level expectations.
module tb_spi_controller;

  function automatic int f_tx(int i);   return (i == 2) ? 4 : 8; endfunction
  function automatic int f_rx(int i);   return (i == 2) ? 12 : 8; endfunction
  function automatic int f_div(int i);  return (i == 0) ? 2 : ((i == 1) ? 1 : 7); endfunction
  function automatic int f_gap(int i);  return (i == 2) ? 3 : 4; endfunction
  function automatic logic [15:0] mask(int w); return 16'((32'h1 << w) - 1); endfunction

  typedef struct packed {
    logic [1:0]  lane;
    logic [15:0] tx;
    logic [15:0] rx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_v   = 3'b111;
  logic [2:0]       start_v = 3'b000;
  logic [2:0]       cipo_v  = 3'b000;
  logic [2:0][15:0] tx_v    = '0;

  wire [2:0]        busy_w, done_w, sck_w, copi_w, cs_w;
  wire [2:0][15:0]  rx_w;

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LTX = f_tx(g);
    localparam int LRX = f_rx(g);
    wire [LRX-1:0] rx_l;
    spi_controller #(
      .LENGTH_TX(LTX), .LENGTH_RX(LRX), .CLK_DIV(f_div(g)), .CS_GAP(f_gap(g)), .LENGTH_COUNT(5)
    ) dut (
      .clk(clk), .rst(rst_v[g]), .start(start_v[g]), .tx_data(tx_v[g][LTX-1:0]),
      .busy(busy_w[g]), .done(done_w[g]), .rx_data(rx_l),
      .SCK(sck_w[g]), .COPI(copi_w[g]), .CIPO(cipo_v[g]), .CS(cs_w[g])
    );
    assign rx_w[g] = 16'(rx_l);
  end

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  task automatic check(string name, int ln, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s lane %0d: got %0h want %0h", name, ln, got, want);
  endtask

  // Monitor and peripheral model state, per lane.
  logic [2:0]  rst_d = 3'b111;
  logic [2:0]  sck_prev, cs_prev, busy_prev;
  logic [15:0] rx_prev[3];
  logic [15:0] cap[3];
  logic [2:0]  flags[3];
  int rises[3], last_edge[3], cs_fall_cyc[3], cs_rise_cyc[3], done_cyc[3];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst_d[i]) begin
        check("reset_values", i, {cs_w[i], sck_w[i], busy_w[i], done_w[i], copi_w[i], rx_w[i]},
              {5'b10000, 16'h0000});
        rises[i] = 0; cipo_v[i] = 1'b0; flags[i] = '0; cap[i] = '0;
        cs_rise_cyc[i] = -1000; done_cyc[i] = cyc; last_edge[i] = cyc; cs_fall_cyc[i] = cyc;
      end else begin
        if (!cs_w[i] && cs_prev[i]) begin
          int gap;
          gap = cyc - cs_rise_cyc[i];
          check("cs_fall_with_busy_rise", i, {busy_w[i], busy_prev[i]}, 2'b10);
          check("cs_high_gap", i, (gap >= f_gap(i)) ? f_gap(i) : gap, f_gap(i));
          cs_fall_cyc[i] = cyc; last_edge[i] = cyc; rises[i] = 0; cap[i] = '0; flags[i] = '0;
        end
        if (cs_w[i] && !cs_prev[i]) cs_rise_cyc[i] = cyc;
        if (sck_w[i] && !sck_prev[i]) begin
          if (cyc - last_edge[i] != f_div(i)) flags[i][0] = 1'b1;
          last_edge[i] = cyc;
          rises[i]++;
          if (rises[i] <= f_tx(i)) cap[i][rises[i]-1] = copi_w[i];
          else if (copi_w[i]) flags[i][1] = 1'b1;
        end
        if (!sck_w[i] && sck_prev[i]) begin
          int k;
          if (cyc - last_edge[i] != f_div(i)) flags[i][0] = 1'b1;
          last_edge[i] = cyc;
          k = rises[i] - f_tx(i) - 1;
          // Peripheral shifts its word out LSB-first, changing CIPO only after SCK falls.
          cipo_v[i] = (q.size() > 0 && int'(q[0].lane) == i && k >= 0 && k < f_rx(i)) ? q[0].rx[k] : 1'b0;
        end
        if (!done_w[i] && rx_w[i] != rx_prev[i]) flags[i][2] = 1'b1;
        if (done_w[i]) begin
          if (q.size() == 0 || int'(q[0].lane) != i) begin
            n_total++;
            $display("FAIL unexpected_done lane %0d: got done with rx %0h, want no done", i, rx_w[i]);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("rx_data", i, rx_w[i], e.rx);
            check("peripheral_copi_word", i, cap[i], e.tx);
            check("sck_rises", i, rises[i], f_tx(i) + 1 + f_rx(i));
            check("done_latency", i, cyc - cs_fall_cyc[i], (2 * (f_tx(i) + 1 + f_rx(i)) + 1) * f_div(i));
            check("cs_high_at_done", i, cs_w[i], 1);
            check("timing_copi_stable_flags", i, flags[i], 3'b000);
          end
          done_cyc[i] = cyc;
        end
        if (!busy_w[i] && busy_prev[i]) check("busy_fall_after_done", i, cyc - done_cyc[i], f_gap(i));
      end
      sck_prev[i] = sck_w[i]; cs_prev[i] = cs_w[i]; busy_prev[i] = busy_w[i]; rx_prev[i] = rx_w[i];
      rst_d[i] = rst_v[i];
    end
  end

  task automatic wait_busy(int ln, logic val);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (busy_w[ln] === val) return;
    end
    n_total++;
    $display("FAIL wait_busy_timeout lane %0d: got busy=%b, want %b", ln, busy_w[ln], val);
  endtask

  task automatic issue(int ln, logic [15:0] tx, logic [15:0] rx);
    exp_t e;
    e.lane = 2'(ln); e.tx = tx & mask(f_tx(ln)); e.rx = rx & mask(f_rx(ln));
    q.push_back(e);
    start_v[ln] = 1'b1; tx_v[ln] = e.tx;
    wait_busy(ln, 1'b1);
    start_v[ln] = 1'b0; tx_v[ln] = 16'($urandom);
  endtask

  task automatic frame(int ln, logic [15:0] tx, logic [15:0] rx);
    issue(ln, tx, rx);
    wait_busy(ln, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_v = 3'b000;
    repeat (2) @(posedge clk);
    #1;

    frame(0, 16'hA5, 16'h3C);
    for (int n = 0; n < 4; n++) frame(0, 16'($urandom), 16'($urandom));

    // Back-to-back with start held high.
    begin
      exp_t e1, e2;
      e1.lane = 2'd0; e1.tx = 16'h01; e1.rx = 16'($urandom) & 16'hFF;
      e2.lane = 2'd0; e2.tx = 16'hFF; e2.rx = 16'($urandom) & 16'hFF;
      q.push_back(e1); q.push_back(e2);
      start_v[0] = 1'b1; tx_v[0] = 16'h01;
      wait_busy(0, 1'b1);
      tx_v[0] = 16'hFF;
      wait_busy(0, 1'b0);
      wait_busy(0, 1'b1);
      start_v[0] = 1'b0; tx_v[0] = 16'($urandom);
      wait_busy(0, 1'b0);
    end

    // Start pulse mid-frame must be ignored.
    issue(0, 16'($urandom), 16'($urandom));
    repeat (20) @(posedge clk);
    #1 start_v[0] = 1'b1; tx_v[0] = 16'h00;
    @(posedge clk); #1 start_v[0] = 1'b0;
    wait_busy(0, 1'b0);

    // Reset after the 5th SCK rise, then a clean frame.
    issue(0, 16'($urandom), 16'($urandom));
    for (int c = 0; c < 1000 && rises[0] < 5; c++) begin @(posedge clk); #1; end
    if (rises[0] < 5) begin
      n_total++;
      $display("FAIL rise5_timeout lane 0: got %0d rises, want 5", rises[0]);
    end
    rst_v[0] = 1'b1;
    q.delete();
    @(posedge clk); #1 rst_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    frame(0, 16'h5A, 16'hC3);

    frame(1, 16'h55, 16'hAA);
    frame(1, 16'hAA, 16'h55);
    for (int n = 0; n < 3; n++) frame(1, 16'($urandom), 16'($urandom));

    frame(2, 16'h9, 16'hABC);
    for (int n = 0; n < 3; n++) frame(2, 16'($urandom), 16'($urandom));

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 0, q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1);
  end

endmodule
